port_uart_tx: RTL and testbench

- Serial transmitter that sits directly downstream of the MCU2 output port.
- Consumes bytes the controller writes to the port and shifts them out on a single pin as 8N1 UART frames.
- Contains a small write FIFO so the controller can post several bytes without polling.
- Status outputs (full, busy, overflow) feed back to portIn bits so firmware can throttle writes.

---
 rtl/mcu_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/port_uart_tx.sv | 184 ++++++++++++++++++
 tb/tb_port_uart_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Purpose : shared types and constants for the MCU2 port peripherals.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: UART FSM state enum, byte width, default bit divider, and a
//           helper that sizes a down-counter able to hold CLK_DIV-1.
package mcu_pkg;

  // Transmitter FSM states; 2-bit encoding keeps the state flop count minimal.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uartState_t;

  localparam int UART_DATA_W = 8;

  // Controller firmware and the bench both assume this bit period by default.
  localparam int UART_CLK_DIV_DEFAULT = 16;

  // Width of a down-counter loaded with div-1. A divider of 1 still needs a
  // 1-bit counter so the vector never collapses to zero width.
  function automatic int divWidth(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Purpose : single-clock FIFO with occupancy count and flop-based head output.
// Latency : a push is visible at head/count on the next clk edge.
// Backpressure: pushes while full and pops while empty are ignored.
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   push, pushData    write strobe and data (dropped when full)
//   pop               remove head entry (ignored when empty)
//   head              oldest entry, read straight from storage flops
//   full, empty       occupancy flags decoded from the registered count
//   count             entries currently stored
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] cnt;
  logic             doPush;
  logic             doPop;

  assign full   = (cnt == CNT_W'(DEPTH));
  assign empty  = (cnt == '0);
  assign count  = cnt;
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign head   = mem[rdPtr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: resetting the pointers and count discards it.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/port_uart_tx.sv
// Purpose : 8N1 UART transmitter fed by the MCU2 output port through a small FIFO.
// Latency : byte written into an empty FIFO while idle -> start bit on txd one edge later.
// Backpressure: none on the write side; writes while full are dropped and flagged in overflow.
// Ports:
//   clk, rst     rising-edge clock, async active-high reset (aborts any frame)
//   wr_en        one-cycle write strobe, wr_data sampled with it
//   clr_ovf      clears the sticky overflow flag (a same-edge drop wins)
//   txd          serial line, idle high, driven from a flop
//   busy         frame on the line or bytes queued (registered)
//   full         FIFO holds FIFO_DEPTH entries
//   overflow     sticky: at least one write was dropped
//   fifo_count   queued entries, not counting the byte being shifted
module port_uart_tx
  import mcu_pkg::*;
#(
  parameter int CLK_DIV    = UART_CLK_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             clr_ovf,
  output logic             txd,
  output logic             busy,
  output logic             full,
  output logic             overflow,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int                    DIV_W    = divWidth(CLK_DIV);
  localparam logic [DIV_W-1:0]      DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]            BIT_LAST = 3'(UART_DATA_W - 1);

  uartState_t             state;
  logic [DIV_W-1:0]       divCnt;
  logic [2:0]             bitIdx;
  logic [UART_DATA_W-1:0] shiftReg;
  logic                   txdReg;
  logic                   busyReg;
  logic                   ovfReg;

  logic [UART_DATA_W-1:0] fifoHead;
  logic                   fifoFull;
  logic                   fifoEmpty;
  logic [CNT_W-1:0]       fifoCount;

  logic                   pushReq;
  logic                   popReq;
  logic                   bitDone;
  logic                   enterIdle;
  logic [CNT_W-1:0]       countNext;

  // A write against a full FIFO is dropped even if a pop frees a slot on the
  // same edge; full is the registered value, so this has no timing surprises.
  assign pushReq = wr_en && !fifoFull;
  assign bitDone = (divCnt == '0);

  // Pop when idle, or on the final STOP cycle so frames run back-to-back.
  assign popReq  = !fifoEmpty &&
                   ((state == IDLE) || ((state == STOP) && bitDone));

  // FSM will be in IDLE after this edge.
  assign enterIdle = !popReq &&
                     ((state == IDLE) || ((state == STOP) && bitDone));

  always_comb begin
    countNext = fifoCount;
    if (pushReq && !popReq)      countNext = fifoCount + 1'b1;
    else if (!pushReq && popReq) countNext = fifoCount - 1'b1;
  end

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pushReq),
    .pushData (wr_data),
    .pop      (popReq),
    .head     (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  // Frame FSM, divider and shifter. txd is loaded with the value for the
  // coming bit period at each transition so it never passes through logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      divCnt   <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      txdReg   <= 1'b1;
      busyReg  <= 1'b0;
    end else begin
      // busy is computed from next-state values so it is glitch-free and
      // falls on the same edge the FSM returns to IDLE with nothing queued.
      busyReg <= !(enterIdle && (countNext == '0));

      case (state)
        IDLE: begin
          txdReg <= 1'b1;
          if (popReq) begin
            shiftReg <= fifoHead;
            divCnt   <= DIV_LOAD;
            txdReg   <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (bitDone) begin
            divCnt <= DIV_LOAD;
            bitIdx <= '0;
            txdReg <= shiftReg[0];
            state  <= DATA;
          end else begin
            divCnt <= divCnt - 1'b1;
          end
        end

        DATA: begin
          if (bitDone) begin
            divCnt <= DIV_LOAD;
            if (bitIdx == BIT_LAST) begin
              txdReg <= 1'b1;
              state  <= STOP;
            end else begin
              // shiftReg[1] becomes shiftReg[0] after this shift.
              shiftReg <= {1'b0, shiftReg[UART_DATA_W-1:1]};
              bitIdx   <= bitIdx + 1'b1;
              txdReg   <= shiftReg[1];
            end
          end else begin
            divCnt <= divCnt - 1'b1;
          end
        end

        STOP: begin
          if (bitDone) begin
            if (popReq) begin
              shiftReg <= fifoHead;
              divCnt   <= DIV_LOAD;
              txdReg   <= 1'b0;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            divCnt <= divCnt - 1'b1;
          end
        end

        default: begin
          txdReg <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Sticky drop flag; a drop on the same edge as clr_ovf keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovfReg <= 1'b0;
    end else if (wr_en && fifoFull) begin
      ovfReg <= 1'b1;
    end else if (clr_ovf) begin
      ovfReg <= 1'b0;
    end
  end

  assign txd        = txdReg;
  assign busy       = busyReg;
  assign full       = fifoFull;
  assign overflow   = ovfReg;
  assign fifo_count = fifoCount;

endmodule

// File: tb/tb_port_uart_tx.sv
// Purpose : directed self-checking bench for port_uart_tx at CLK_DIV 4, 2 and 1.
// Latency : inputs driven on the falling edge, outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_port_uart_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // CLK_DIV=4 instance
  logic       wrEn4, clrOvf4, txd4, busy4, full4, ovf4;
  logic [7:0] wrData4;
  logic [2:0] cnt4;
  // CLK_DIV=2 instance
  logic       wrEn2, clrOvf2, txd2, busy2, full2, ovf2;
  logic [7:0] wrData2;
  logic [2:0] cnt2;
  // CLK_DIV=1 instance
  logic       wrEn1, clrOvf1, txd1, busy1, full1, ovf1;
  logic [7:0] wrData1;
  logic [2:0] cnt1;

  int testsRun  = 0;
  int failCount = 0;

  port_uart_tx #(.CLK_DIV(4), .FIFO_DEPTH(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst(rst), .wr_en(wrEn4), .wr_data(wrData4), .clr_ovf(clrOvf4),
    .txd(txd4), .busy(busy4), .full(full4), .overflow(ovf4), .fifo_count(cnt4));

  port_uart_tx #(.CLK_DIV(2), .FIFO_DEPTH(4), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wrEn2), .wr_data(wrData2), .clr_ovf(clrOvf2),
    .txd(txd2), .busy(busy2), .full(full2), .overflow(ovf2), .fifo_count(cnt2));

  port_uart_tx #(.CLK_DIV(1), .FIFO_DEPTH(4), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wrEn1), .wr_data(wrData1), .clr_ovf(clrOvf1),
    .txd(txd1), .busy(busy1), .full(full1), .overflow(ovf1), .fifo_count(cnt1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for frame slot idx: start, 8 data bits LSB first, stop.
  function automatic logic frameBit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  function automatic logic txdOf(input int w);
    case (w)
      4:       return txd4;
      2:       return txd2;
      default: return txd1;
    endcase
  endfunction

  function automatic logic busyOf(input int w);
    case (w)
      4:       return busy4;
      2:       return busy2;
      default: return busy1;
    endcase
  endfunction

  // Checks frame cycles firstIdx..lastIdx, one per falling edge, starting with
  // the cycle currently visible; returns with cycle lastIdx+1 visible.
  task automatic checkFrame(input int w, input int div, input logic [7:0] b,
                            input int firstIdx, input int lastIdx, input string tag);
    for (int i = firstIdx; i <= lastIdx; i++) begin
      check($sformatf("%s cyc%0d txd", tag, i), 32'(txdOf(w)), 32'(frameBit(b, i / div)));
      check($sformatf("%s cyc%0d busy", tag, i), 32'(busyOf(w)), 32'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failed %0d of %0d so far", failCount, testsRun);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    wrEn4 = 0; clrOvf4 = 0; wrData4 = '0;
    wrEn2 = 0; clrOvf2 = 0; wrData2 = '0;
    wrEn1 = 0; clrOvf1 = 0; wrData1 = '0;
    #2;
    check("rst txd",   32'(txd4), 32'd1);
    check("rst busy",  32'(busy4), 32'd0);
    check("rst full",  32'(full4), 32'd0);
    check("rst ovf",   32'(ovf4), 32'd0);
    check("rst count", 32'(cnt4), 32'd0);
    check("rst txd2",  32'(txd2), 32'd1);
    check("rst txd1",  32'(txd1), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single byte, CLK_DIV=4
    wrEn4 = 1; wrData4 = 8'hA5;
    @(negedge clk);
    wrEn4 = 0;
    check("a5 count after write", 32'(cnt4), 32'd1);
    check("a5 txd before start",  32'(txd4), 32'd1);
    check("a5 busy after write",  32'(busy4), 32'd1);
    @(negedge clk);
    check("a5 count after pop", 32'(cnt4), 32'd0);
    checkFrame(4, 4, 8'hA5, 0, 39, "a5");
    check("a5 idle txd",  32'(txd4), 32'd1);
    check("a5 idle busy", 32'(busy4), 32'd0);

    // Back-to-back, CLK_DIV=2
    wrEn2 = 1; wrData2 = 8'h00;
    @(negedge clk);
    check("b2b count 1st", 32'(cnt2), 32'd1);
    wrData2 = 8'hFF;
    @(negedge clk);
    wrEn2 = 0;
    check("b2b count 2nd", 32'(cnt2), 32'd1);
    checkFrame(2, 2, 8'h00, 0, 19, "b2b00");
    check("b2b count 3rd", 32'(cnt2), 32'd0);
    checkFrame(2, 2, 8'hFF, 0, 19, "b2bff");
    check("b2b idle txd",  32'(txd2), 32'd1);
    check("b2b idle busy", 32'(busy2), 32'd0);

    // CLK_DIV=1
    wrEn1 = 1; wrData1 = 8'h3C;
    @(negedge clk);
    wrEn1 = 0;
    @(negedge clk);
    checkFrame(1, 1, 8'h3C, 0, 9, "div1");
    check("div1 idle txd",  32'(txd1), 32'd1);
    check("div1 idle busy", 32'(busy1), 32'd0);

    // Fill and overflow, CLK_DIV=4
    wrEn4 = 1; wrData4 = 8'h11;
    @(negedge clk);
    wrData4 = 8'h22;
    @(negedge clk);
    wrData4 = 8'h33;
    @(negedge clk);
    wrData4 = 8'h44;
    @(negedge clk);
    wrData4 = 8'h55;
    @(negedge clk);
    check("fill full after 5th", 32'(full4), 32'd1);
    check("fill count after 5th", 32'(cnt4), 32'd4);
    check("fill ovf before 6th", 32'(ovf4), 32'd0);
    wrData4 = 8'h66;
    @(negedge clk);
    wrEn4 = 0;
    check("fill ovf after 6th", 32'(ovf4), 32'd1);
    check("fill full after 6th", 32'(full4), 32'd1);
    check("fill count after 6th", 32'(cnt4), 32'd4);
    checkFrame(4, 4, 8'h11, 4, 39, "fill11");
    checkFrame(4, 4, 8'h22, 0, 39, "fill22");
    checkFrame(4, 4, 8'h33, 0, 39, "fill33");
    checkFrame(4, 4, 8'h44, 0, 39, "fill44");
    checkFrame(4, 4, 8'h55, 0, 39, "fill55");
    check("fill idle txd",   32'(txd4), 32'd1);
    check("fill idle busy",  32'(busy4), 32'd0);
    check("fill idle count", 32'(cnt4), 32'd0);
    check("fill ovf sticky", 32'(ovf4), 32'd1);
    clrOvf4 = 1;
    @(negedge clk);
    clrOvf4 = 0;
    check("fill ovf cleared", 32'(ovf4), 32'd0);

    // Push and pop on the same edge (last STOP cycle, count=1)
    wrEn4 = 1; wrData4 = 8'hAA;
    @(negedge clk);
    wrData4 = 8'hBB;
    @(negedge clk);
    wrEn4 = 0;
    check("pp count queued", 32'(cnt4), 32'd1);
    checkFrame(4, 4, 8'hAA, 0, 38, "ppAA");
    wrEn4 = 1; wrData4 = 8'hCC;
    check("pp last stop txd", 32'(txd4), 32'd1);
    check("pp count before", 32'(cnt4), 32'd1);
    @(negedge clk);
    wrEn4 = 0;
    check("pp count same", 32'(cnt4), 32'd1);
    checkFrame(4, 4, 8'hBB, 0, 39, "ppBB");
    check("pp count drained", 32'(cnt4), 32'd0);
    checkFrame(4, 4, 8'hCC, 0, 39, "ppCC");
    check("pp idle txd",  32'(txd4), 32'd1);
    check("pp idle busy", 32'(busy4), 32'd0);

    // Reset during DATA bit 3 (bit 3 of 0x50 is 0, so the async rise is visible)
    wrEn4 = 1; wrData4 = 8'h50;
    @(negedge clk);
    wrData4 = 8'h77;
    @(negedge clk);
    wrEn4 = 0;
    check("mid count queued", 32'(cnt4), 32'd1);
    checkFrame(4, 4, 8'h50, 0, 17, "mid50");
    check("mid bit3 low", 32'(txd4), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("mid rst txd",   32'(txd4), 32'd1);
    check("mid rst busy",  32'(busy4), 32'd0);
    check("mid rst count", 32'(cnt4), 32'd0);
    check("mid rst full",  32'(full4), 32'd0);
    check("mid rst ovf",   32'(ovf4), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post rst txd",   32'(txd4), 32'd1);
    check("post rst busy",  32'(busy4), 32'd0);
    check("post rst count", 32'(cnt4), 32'd0);
    wrEn4 = 1; wrData4 = 8'hC3;
    @(negedge clk);
    wrEn4 = 0;
    @(negedge clk);
    checkFrame(4, 4, 8'hC3, 0, 39, "postC3");
    check("post idle txd",  32'(txd4), 32'd1);
    check("post idle busy", 32'(busy4), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
